// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream feeding the ccff chain loader: one word per s_valid & s_ready handshake.
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words MSB first onto one ccff chain segment, pulsing shift enable for exactly CHAIN_LEN cycles.
// s_ready only in FETCH (stall holds the chain); CCFF_VERIFY_EN adds a tail-vs-head compare for reloads of the same stream.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 30,
    parameter int WORD_W    = 8
) (
    input  logic prog_clk,
    input  logic prog_reset_n,
    input  logic cfg_start,
    input  logic cfg_abort,
    ccff_chain_loader_if.slave s,
    output logic ccff_head,
    output logic ccff_shift_en,
    input  logic ccff_tail,
`ifdef CCFF_VERIFY_EN
    input  logic cfg_verify,
    output logic cfg_mismatch,
`endif
    output logic cfg_busy,
    output logic cfg_done
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WL_W  = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    state_t            state_q;
    logic [WORD_W-1:0] shift_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [CNT_W-1:0]  bit_cnt_d;
    logic [WL_W-1:0]   word_left_q;
    logic [WL_W-1:0]   word_len_d;
    logic [31:0]       bits_left;
    logic              s_ready_q;
    logic              head_q;
    logic              shift_en_q;
    logic              busy_q;
    logic              done_q;
    logic              accept;

    // The final word may carry fewer useful bits than WORD_W; its low bits are never shifted.
    assign bits_left  = 32'(CHAIN_LEN) - 32'(bit_cnt_q);
    assign word_len_d = (bits_left < 32'(WORD_W)) ? WL_W'(bits_left) : WL_W'(WORD_W);
    assign bit_cnt_d  = bit_cnt_q + CNT_W'(1);

    // Abort must block a same-cycle handshake and suppress a pending done pulse.
    assign s.s_ready = s_ready_q & ~cfg_abort;
    assign accept    = s.s_valid & s.s_ready;

    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign cfg_busy      = busy_q;
    assign cfg_done      = done_q & ~cfg_abort;

`ifdef CCFF_VERIFY_EN
    logic verify_q;
    logic mismatch_q;
    assign cfg_mismatch = mismatch_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            word_left_q <= '0;
            s_ready_q   <= 1'b0;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef CCFF_VERIFY_EN
            verify_q    <= 1'b0;
            mismatch_q  <= 1'b0;
`endif
        end else if (cfg_abort) begin
            state_q    <= IDLE;
            s_ready_q  <= 1'b0;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        state_q    <= FETCH;
                        s_ready_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        bit_cnt_q  <= '0;
`ifdef CCFF_VERIFY_EN
                        verify_q   <= cfg_verify;
                        mismatch_q <= 1'b0;
`endif
                    end
                end
                FETCH: begin
                    if (accept) begin
                        state_q     <= SHIFT;
                        s_ready_q   <= 1'b0;
                        shift_en_q  <= 1'b1;
                        head_q      <= s.s_data[WORD_W-1];
                        shift_q     <= s.s_data << 1;
                        word_left_q <= word_len_d;
                    end
                end
                SHIFT: begin
`ifdef CCFF_VERIFY_EN
                    if (verify_q && (ccff_tail != head_q)) begin
                        mismatch_q <= 1'b1;
                    end
`endif
                    bit_cnt_q <= bit_cnt_d;
                    if (word_left_q == WL_W'(1)) begin
                        shift_en_q <= 1'b0;
                        head_q     <= 1'b0;
                        if (bit_cnt_d == CNT_W'(CHAIN_LEN)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= FETCH;
                            s_ready_q <= 1'b1;
                        end
                    end else begin
                        head_q      <= shift_q[WORD_W-1];
                        shift_q     <= shift_q << 1;
                        word_left_q <= word_left_q - WL_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed + randomized bench for ccff_chain_loader against a stream-level model and a 30-bit chain model.
module tb_ccff_chain_loader;
    localparam int L  = 30;
    localparam int W  = 8;
    localparam int NW = (L + W - 1) / W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic head, sen, busy, done, tail;
    logic [L-1:0] chain = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0, hs_cnt = 0, done_cnt = 0, start_cyc = 0, done_cyc = 0;
    logic obs[$];
    logic [W-1:0] wds[NW];
    int gaps[NW];
    int base_g, d0_g, hs0_g;
    bit ok_g;

    ccff_chain_loader_if #(.WORD_W(W)) bus();

`ifdef CCFF_VERIFY_EN
    logic verify = 1'b0;
    logic mism;
    logic [L-1:0] prev_bits;
`endif

    ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
        .prog_clk      (clk),
        .prog_reset_n  (rst_n),
        .cfg_start     (start),
        .cfg_abort     (abort),
        .s             (bus),
        .ccff_head     (head),
        .ccff_shift_en (sen),
        .ccff_tail     (tail),
`ifdef CCFF_VERIFY_EN
        .cfg_verify    (verify),
        .cfg_mismatch  (mism),
`endif
        .cfg_busy      (busy),
        .cfg_done      (done)
    );

    always #5 clk = ~clk;

    // Physical chain: captures head on every enabled prog_clk edge.
    always @(posedge clk) if (sen) chain <= {chain[L-2:0], head};
    assign tail = chain[L-1];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (sen) obs.push_back(head);
        if (bus.s_valid && bus.s_ready) hs_cnt <= hs_cnt + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (start && !busy && !abort && rst_n) start_cyc <= cyc;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Stream order: word 0 MSB first, truncated to L bits; first bit lands in the vector MSB.
    function automatic logic [L-1:0] model_bits();
        logic [L-1:0] v = '0;
        int n = 0;
        for (int i = 0; i < NW; i++)
            for (int b = W - 1; b >= 0; b--)
                if (n < L) begin
                    v[L-1-n] = wds[i][b];
                    n++;
                end
        return v;
    endfunction

    function automatic logic [L-1:0] obs_bits(input int base);
        logic [L-1:0] v = 'x;
        for (int k = 0; k < L; k++)
            if (base + k < obs.size()) v[L-1-k] = obs[base+k];
        return v;
    endfunction

    function automatic int gap_sum();
        int s = 0;
        for (int i = 0; i < NW; i++) s += gaps[i];
        return s;
    endfunction

    task automatic load(input bit restart, input int abort_at);
        int n;
        ok_g = 1'b1;
        @(posedge clk); #1;
        start  = 1'b1;
        base_g = obs.size();
        d0_g   = done_cnt;
        hs0_g  = hs_cnt;
        @(posedge clk); #1;
        start = restart;
        for (int i = 0; i < NW; i++) begin
            if (gaps[i] == 0) begin
                bus.s_valid = 1'b1;
                bus.s_data  = wds[i];
            end else begin
                bus.s_valid = 1'b0;
                bus.s_data  = W'($urandom);
            end
            n = 0;
            do begin @(negedge clk); #1; n++; end while (!bus.s_ready && n < 200);
            if (n >= 200) ok_g = 1'b0;
            if (gaps[i] > 0) begin
                repeat (gaps[i]) @(posedge clk);
                #1;
                bus.s_valid = 1'b1;
                bus.s_data  = wds[i];
            end
            @(posedge clk); #1;
            start       = 1'b0;
            bus.s_valid = 1'b0;
            if (abort_at > 0 && abort_at <= (i + 1) * W) begin
                n = 0;
                while (obs.size() - base_g < abort_at && n < 200) begin
                    @(negedge clk); #1; n++;
                end
                if (n >= 200) ok_g = 1'b0;
                @(posedge clk); #1; abort = 1'b1;
                @(posedge clk); #1; abort = 1'b0;
                return;
            end
        end
        n = 0;
        while (done_cnt == d0_g && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 200) ok_g = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic load_checks(input string tag);
        chk({tag, "_ok"},   64'(ok_g), 64'(1));
        chk({tag, "_bits"}, 64'(obs_bits(base_g)), 64'(model_bits()));
        chk({tag, "_nbits"}, 64'(obs.size() - base_g), 64'(L));
        chk({tag, "_hs"},   64'(hs_cnt - hs0_g), 64'(NW));
        chk({tag, "_done"}, 64'(done_cnt - d0_g), 64'(1));
        chk({tag, "_lat"},  64'(done_cyc - start_cyc), 64'(1 + NW + L + 1 - 1 + gap_sum()));
        chk({tag, "_idle"}, 64'(busy), 64'(0));
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_sen",  64'(sen),  64'(0));
        chk("rst_head", 64'(head), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_rdy",  64'(bus.s_ready), 64'(0));
`ifdef CCFF_VERIFY_EN
        chk("rst_mism", 64'(mism), 64'(0));
`endif
        rst_n = 1'b1;

        // Reference stream A5,3C,F0,B4 with no stalls.
        wds[0] = 8'hA5; wds[1] = 8'h3C; wds[2] = 8'hF0; wds[3] = 8'hB4;
        for (int i = 0; i < NW; i++) gaps[i] = 0;
        load(1'b0, 0);
        load_checks("t2");
        chk("t2_literal", 64'(obs_bits(base_g)), 64'(30'b101001010011110011110000101101));

        gaps[2] = 5;
        load(1'b0, 0);
        load_checks("t3");

        gaps[2] = 0;
        load(1'b1, 0);
        load_checks("t5");

        load(1'b0, 12);
        chk("t4_busy", 64'(busy), 64'(0));
        chk("t4_sen",  64'(sen),  64'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("t4_nodone", 64'(done_cnt - d0_g), 64'(0));
        chk("t4_nbits",  64'(obs.size() - base_g), 64'(13));
        load(1'b0, 0);
        load_checks("t4_reload");

        // Abort in FETCH while a word is offered: must not handshake.
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        hs0_g = hs_cnt;
        bus.s_valid = 1'b1; bus.s_data = 8'h5A; abort = 1'b1;
        @(negedge clk); #1;
        chk("abf_rdy", 64'(bus.s_ready), 64'(0));
        @(posedge clk); #1; abort = 1'b0; bus.s_valid = 1'b0;
        chk("abf_busy", 64'(busy), 64'(0));
        @(negedge clk); #1;
        chk("abf_hs", 64'(hs_cnt - hs0_g), 64'(0));

        // Start and abort together in IDLE: abort wins.
        @(posedge clk); #1; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        chk("sa_busy", 64'(busy), 64'(0));
        chk("sa_rdy",  64'(bus.s_ready), 64'(0));

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NW; i++) begin
                wds[i]  = W'($urandom);
                gaps[i] = $urandom_range(0, 3);
            end
            load(1'b0, 0);
            load_checks($sformatf("rnd%0d", r));
        end

        // Reset in the middle of shifting.
        for (int i = 0; i < NW; i++) gaps[i] = 0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; bus.s_valid = 1'b1; bus.s_data = 8'hC3;
        @(posedge clk); #1; bus.s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t1_sen_pre", 64'(sen), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t1_sen",  64'(sen),  64'(0));
        chk("t1_head", 64'(head), 64'(0));
        chk("t1_busy", 64'(busy), 64'(0));
        chk("t1_done", 64'(done), 64'(0));
        chk("t1_rdy",  64'(bus.s_ready), 64'(0));
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t1_idle", 64'(busy), 64'(0));
        load(1'b0, 0);
        load_checks("t1_reload");

`ifdef CCFF_VERIFY_EN
        for (int i = 0; i < NW; i++) wds[i] = W'($urandom);
        verify = 1'b0;
        load(1'b0, 0);
        load_checks("t6_base");
        prev_bits = model_bits();
        verify = 1'b1;
        load(1'b0, 0);
        chk("t6_same", 64'(mism), 64'(prev_bits != model_bits()));
        wds[0][0] = ~wds[0][0];
        load(1'b0, 0);
        chk("t6_flip", 64'(mism), 64'(prev_bits != model_bits()));
        verify = 1'b0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("t6_clear", 64'(mism), 64'(0));
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
